tt_gpio_ctrl: RTL and testbench

// Controller-side companion of the per-pad GPIO wrapper. It generates the

---
 rtl/tt_gpio_ctrl.sv | 100 ++++++++++
 tb/tb_tt_gpio_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_gpio_ctrl.sv
// Controller-side GPIO pad companion: registered pad drive, synchronised and
// debounced pad input with edge pulses, and a sticky drive-conflict monitor.
module tt_gpio_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILT_W       = 4,
    parameter int CONFLICT_CYC = 8,
    parameter int CHECK_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FILT_W-1:0] cfg_filt,
    input  logic              ctl_out,
    input  logic              ctl_oe,
    input  logic              ctl_clr,
    output logic              ctl_in,
    output logic              ctl_rise,
    output logic              ctl_fall,
    output logic              ctl_conflict,
    output logic              pad_out,
    output logic              pad_oe,
    input  logic              pad_in
);

    localparam int MCNT_W = $clog2(CONFLICT_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   in_q, in_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [MCNT_W-1:0]      mcnt_q, mcnt_d;
    logic                   conf_q, conf_d;
    logic                   pad_out_q, pad_oe_q;
    logic                   mismatch;
    logic                   conf_set;

    assign s = sync_q[SYNC_STAGES-1];

    // A new level is accepted once cnt has reached the threshold while s still
    // differs; >= lets a lowered threshold take effect on the next cycle.
    always_comb begin
        cnt_d  = '0;
        in_d   = in_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != in_q) begin
            if (cnt_q >= cfg_filt) begin
                in_d   = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mismatch = (CHECK_EN != 0) && pad_oe_q && (in_q != pad_out_q);
        mcnt_d   = '0;
        if (mismatch) begin
            mcnt_d = (mcnt_q == MCNT_W'(CONFLICT_CYC)) ? mcnt_q : mcnt_q + 1'b1;
        end
        conf_set = mismatch && (mcnt_q >= MCNT_W'(CONFLICT_CYC - 1));
        // Set has priority over a simultaneous clear.
        conf_d   = conf_set | (conf_q & ~ctl_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            in_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            mcnt_q    <= '0;
            conf_q    <= 1'b0;
            pad_out_q <= 1'b0;
            pad_oe_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_in};
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            mcnt_q    <= mcnt_d;
            conf_q    <= conf_d;
            pad_out_q <= ctl_out;
            pad_oe_q  <= ctl_oe;
        end
    end

    assign ctl_in       = in_q;
    assign ctl_rise     = rise_q;
    assign ctl_fall     = fall_q;
    assign ctl_conflict = conf_q;
    assign pad_out      = pad_out_q;
    assign pad_oe       = pad_oe_q;

endmodule

// File: tb/tb_tt_gpio_ctrl.sv
// Directed bench for tt_gpio_ctrl: expected output vectors are queued as
// stimulus is applied and popped one per cycle against the DUT outputs.
module tb_tt_gpio_ctrl;

    localparam int FILT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [FILT_W-1:0] cfg_filt;
    logic              ctl_out, ctl_oe, ctl_clr;
    logic              ctl_in, ctl_rise, ctl_fall, ctl_conflict;
    logic              pad_out, pad_oe;
    logic              pad_in_drv, loop;
    logic              pad_in;

    assign pad_in = loop ? pad_out : pad_in_drv;

    always #5 clk = ~clk;

    tt_gpio_ctrl #(
        .SYNC_STAGES (2),
        .FILT_W      (FILT_W),
        .CONFLICT_CYC(8),
        .CHECK_EN    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_filt    (cfg_filt),
        .ctl_out     (ctl_out),
        .ctl_oe      (ctl_oe),
        .ctl_clr     (ctl_clr),
        .ctl_in      (ctl_in),
        .ctl_rise    (ctl_rise),
        .ctl_fall    (ctl_fall),
        .ctl_conflict(ctl_conflict),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .pad_in      (pad_in)
    );

    // Vector layout: {pad_oe, pad_out, ctl_conflict, ctl_in, ctl_rise, ctl_fall}
    localparam logic [5:0] ZERO = 6'b000000;
    localparam logic [5:0] OE   = 6'b100000;
    localparam logic [5:0] OUT  = 6'b010000;
    localparam logic [5:0] CONF = 6'b001000;
    localparam logic [5:0] IN   = 6'b000100;
    localparam logic [5:0] RISE = 6'b000010;
    localparam logic [5:0] FALL = 6'b000001;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [5:0] obs();
        return {pad_oe, pad_out, ctl_conflict, ctl_in, ctl_rise, ctl_fall};
    endfunction

    task automatic push(input string tag, input logic [5:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [5:0] o;
        n_checks++;
        o = obs();
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%b required=none", o);
        end else begin
            e = sb.pop_front();
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%b required=%b", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_now();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       v;
        logic       lvl;
        logic [5:0] e;

        rst        = 1'b1;
        cfg_filt   = '0;
        ctl_out    = 1'b0;
        ctl_oe     = 1'b0;
        ctl_clr    = 1'b0;
        pad_in_drv = 1'b0;
        loop       = 1'b0;

        // Reset state
        tick();
        tick();
        push("reset_state", ZERO);
        check_now();
        rst = 1'b0;
        push("idle", ZERO);
        push("idle", ZERO);
        drain(2);

        // Bypass, cfg_filt=0: edge shows up three cycles after pad_in moves
        pad_in_drv = 1'b1;
        push("bypass_rise_lat1", ZERO);
        push("bypass_rise_lat2", ZERO);
        push("bypass_rise", IN | RISE);
        push("bypass_high", IN);
        push("bypass_high", IN);
        drain(5);
        pad_in_drv = 1'b0;
        push("bypass_fall_lat1", IN);
        push("bypass_fall_lat2", IN);
        push("bypass_fall", FALL);
        push("bypass_low", ZERO);
        push("bypass_low", ZERO);
        drain(5);

        // Debounce, cfg_filt=3: a 3-sample glitch is rejected
        cfg_filt   = 4'd3;
        pad_in_drv = 1'b1;
        push("glitch3", ZERO);
        push("glitch3", ZERO);
        push("glitch3", ZERO);
        drain(3);
        pad_in_drv = 1'b0;
        for (int i = 0; i < 6; i++) push("glitch3_after", ZERO);
        drain(6);

        // A 4-sample pulse is accepted, and its trailing low is also filtered
        pad_in_drv = 1'b1;
        for (int i = 0; i < 4; i++) push("pulse4_wait", ZERO);
        drain(4);
        pad_in_drv = 1'b0;
        push("pulse4_wait", ZERO);
        push("pulse4_rise", IN | RISE);
        push("pulse4_high", IN);
        push("pulse4_high", IN);
        push("pulse4_high", IN);
        push("pulse4_fall", FALL);
        push("pulse4_low", ZERO);
        drain(7);

        // Threshold lowered mid-count flips on the next differing cycle
        cfg_filt   = 4'd10;
        pad_in_drv = 1'b1;
        for (int i = 0; i < 8; i++) push("thr_hold", ZERO);
        drain(8);
        cfg_filt = 4'd2;
        push("thr_flip", IN | RISE);
        drain(1);
        cfg_filt   = 4'd0;
        pad_in_drv = 1'b0;
        push("thr_back", IN);
        push("thr_back", IN);
        push("thr_back_fall", FALL);
        push("thr_back_low", ZERO);
        drain(4);

        // Conflict: driving 1 into a pad held at 0
        ctl_oe  = 1'b1;
        ctl_out = 1'b1;
        for (int i = 0; i < 8; i++) push("conf_pending", OE | OUT);
        drain(8);
        push("conf_set", OE | OUT | CONF);
        drain(1);
        ctl_clr = 1'b1;
        push("conf_clr_during_mismatch", OE | OUT | CONF);
        drain(1);
        ctl_clr    = 1'b0;
        pad_in_drv = 1'b1;
        push("conf_sticky", OE | OUT | CONF);
        push("conf_sticky", OE | OUT | CONF);
        push("conf_release_rise", OE | OUT | CONF | IN | RISE);
        push("conf_release_high", OE | OUT | CONF | IN);
        drain(4);
        ctl_clr = 1'b1;
        push("conf_cleared", OE | OUT | IN);
        drain(1);
        ctl_clr = 1'b0;
        push("conf_stays_clear", OE | OUT | IN);
        drain(1);

        // Loopback: period longer than the 4-cycle output-to-input loop
        loop = 1'b1;
        v    = 1'b1;
        for (int t = 0; t < 4; t++) begin
            v       = ~v;
            ctl_out = v;
            for (int j = 1; j <= 6; j++) begin
                lvl = (j >= 4) ? v : ~v;
                e   = OE | (v ? OUT : ZERO) | (lvl ? IN : ZERO);
                if (j == 4) e = e | (v ? RISE : FALL);
                push("loopback", e);
            end
            drain(6);
        end

        // Build up a conflict, then reset mid-run with ctl_oe still 1
        loop       = 1'b0;
        pad_in_drv = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        push("pre_reset_conflict", OE | OUT | CONF);
        check_now();
        #1;
        rst = 1'b1;
        #1;
        push("reset_async", ZERO);
        check_now();
        tick();
        push("reset_hold", ZERO);
        check_now();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push("post_reset_no_edge", OE | OUT);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
